// File: rtl/aurora_tx_arb.sv
// ----------------------------------------------------------------------------
// aurora_tx_arb
//
// Packet-granular arbiter sharing the single Aurora TX AXI-stream among three
// sources: ch0 (buffer-clear / end-packet pops), ch1 (ADC data) and ch2
// (config/status responses). A grant is held from the first beat to tlast, so
// packets never interleave. Arbitration is round-robin, except that while
// pri_lock is high only ch0 may win, which lets clear/end packets preempt data
// at packet boundaries. GAP_CYC idle cycles follow every packet.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   pri_lock     restrict arbitration to ch0 (driven by the pop generator)
//   s_tdata      packed slave data, ch0 at LSBs (3*DATA_WD)
//   s_tkeep      packed slave keep, ch0 at LSBs (3*DATA_WD/8)
//   s_tvalid     per-channel valid
//   s_tlast      per-channel last
//   s_tready     per-channel ready (only the owner sees m_tready)
//   m_tdata      master data
//   m_tkeep      master keep
//   m_tvalid     master valid
//   m_tlast      master last
//   m_tready     master ready
//   grant        one-hot current owner, 0 when nobody owns the bus
//   busy         high while transferring or in the post-packet gap
//   pkt_cnt      packed 32-bit completed-packet counters, ch0 at LSBs
// ----------------------------------------------------------------------------
module aurora_tx_arb #(
    parameter int DATA_WD = 128,
    parameter int GAP_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pri_lock,
    input  logic [3*DATA_WD-1:0]     s_tdata,
    input  logic [3*DATA_WD/8-1:0]   s_tkeep,
    input  logic [2:0]               s_tvalid,
    input  logic [2:0]               s_tlast,
    output logic [2:0]               s_tready,
    output logic [DATA_WD-1:0]       m_tdata,
    output logic [DATA_WD/8-1:0]     m_tkeep,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic [2:0]               grant,
    output logic                     busy,
    output logic [95:0]              pkt_cnt
);

    localparam int KEEP_WD = DATA_WD / 8;
    localparam logic [3:0] GAP_LAST = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  last_q,  last_d;     // channel index of the most recent grant
    logic [3:0]  gap_q,   gap_d;
    logic [31:0] cnt0_q, cnt1_q, cnt2_q;

    logic        pick_ok;
    logic [1:0]  pick_ch;
    logic        beat_end;

    function automatic logic [1:0] next_ch(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    // Arbitration: ch0 only under lock, otherwise scan last+1, last+2, last+3.
    always_comb begin
        logic [1:0] c1, c2, c3;
        c1      = next_ch(last_q);
        c2      = next_ch(c1);
        c3      = next_ch(c2);
        pick_ok = 1'b0;
        pick_ch = 2'd0;
        if (pri_lock) begin
            pick_ok = s_tvalid[0];
            pick_ch = 2'd0;
        end else if (s_tvalid[c1]) begin
            pick_ok = 1'b1;
            pick_ch = c1;
        end else if (s_tvalid[c2]) begin
            pick_ok = 1'b1;
            pick_ch = c2;
        end else if (s_tvalid[c3]) begin
            pick_ok = 1'b1;
            pick_ch = c3;
        end
    end

    assign beat_end = (state_q == XFER) && m_tvalid && m_tready && m_tlast;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 2'd2;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    state_d = XFER;
                    grant_d = 3'b001 << pick_ch;
                    last_d  = pick_ch;
                end
            end
            XFER: begin
                if (beat_end) begin
                    grant_d = '0;
                    gap_d   = '0;
                    state_d = (GAP_CYC == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic: the owner is routed straight through while in XFER.
    always_comb begin
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (state_q == XFER) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (grant_q[i]) begin
                    m_tdata     = s_tdata[i*DATA_WD +: DATA_WD];
                    m_tkeep     = s_tkeep[i*KEEP_WD +: KEEP_WD];
                    m_tvalid    = s_tvalid[i];
                    m_tlast     = s_tlast[i];
                    s_tready[i] = m_tready;
                end
            end
        end
    end

    // Completed-packet counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else if (beat_end) begin
            case (last_q)
                2'd0:    cnt0_q <= cnt0_q + 32'd1;
                2'd1:    cnt1_q <= cnt1_q + 32'd1;
                2'd2:    cnt2_q <= cnt2_q + 32'd1;
                default: ;
            endcase
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign pkt_cnt = {cnt2_q, cnt1_q, cnt0_q};

endmodule

// File: tb/tb_aurora_tx_arb.sv
module tb_aurora_tx_arb;

    localparam int DW  = 128;
    localparam int KW  = DW / 8;
    localparam int GAP = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pri_lock = 1'b0;
    logic [3*DW-1:0]   s_tdata = '0;
    logic [3*KW-1:0]   s_tkeep = '0;
    logic [2:0]        s_tvalid = '0;
    logic [2:0]        s_tlast = '0;
    logic [2:0]        s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready = 1'b1;
    logic [2:0]        grant;
    logic              busy;
    logic [95:0]       pkt_cnt;

    always #5 clk = ~clk;

    aurora_tx_arb #(
        .DATA_WD (DW),
        .GAP_CYC (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pri_lock (pri_lock),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .grant    (grant),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        logic [1:0]    ch;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } exp_t;

    typedef struct {
        logic       lock;
        logic [2:0] mask;
        logic [1:0] exp_ch;
    } vec_t;

    beat_t       src [3][$];
    exp_t        sb[$];
    exp_t        held[$];
    logic [31:0] exp_cnt [3];
    logic [2:0]  fire = '0;
    int          checks = 0;
    int          errors = 0;
    int          pkt_id = 0;
    bit          chk_gap = 1'b0;
    bit          have_prev = 1'b0;
    bit          in_pkt = 1'b0;
    int          lowcnt = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input exp_t e);
        sb.push_back(e);
        if (e.l) exp_cnt[e.ch] = exp_cnt[e.ch] + 32'd1;
    endtask

    // Queue a packet on a source; its beats go to the scoreboard now or are
    // parked in 'held' until the bench decides the packet may be granted.
    task automatic make_pkt(input int ch, input int n, input bit hold);
        for (int b = 0; b < n; b++) begin
            beat_t bt;
            exp_t  e;
            bt.d = {$urandom, $urandom, 8'(ch), 8'(b), 16'(pkt_id), $urandom};
            bt.k = (b == n - 1) ? (16'($urandom) | 16'h0001) : 16'hFFFF;
            bt.l = (b == n - 1);
            src[ch].push_back(bt);
            e.ch = 2'(ch);
            e.d  = bt.d;
            e.k  = bt.k;
            e.l  = bt.l;
            if (hold) held.push_back(e);
            else push_exp(e);
        end
        pkt_id++;
    endtask

    task automatic release_held();
        while (held.size() > 0) push_exp(held.pop_front());
    endtask

    task automatic flush_src();
        for (int c = 0; c < 3; c++) src[c].delete();
        held.delete();
    endtask

    task automatic wait_sb(input int max_cyc, input string tag);
        for (int k = 0; k < max_cyc && sb.size() > 0; k++) step();
        chk({tag, "_drain"}, DW'(sb.size()), '0);
    endtask

    task automatic chk_cnt(input string tag);
        chk(tag, DW'(pkt_cnt), DW'({exp_cnt[2], exp_cnt[1], exp_cnt[0]}));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, DW'({grant, busy, m_tvalid, m_tlast, s_tready, m_tkeep}), '0);
        chk({tag, "_data"}, m_tdata, '0);
    endtask

    // Source models: retire a beat that handshook, then present the next one.
    always begin
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            if (fire[c] && src[c].size() > 0) void'(src[c].pop_front());
            if (src[c].size() > 0) begin
                s_tvalid[c]           = 1'b1;
                s_tdata[c*DW +: DW]   = src[c][0].d;
                s_tkeep[c*KW +: KW]   = src[c][0].k;
                s_tlast[c]            = src[c][0].l;
            end else begin
                s_tvalid[c]           = 1'b0;
                s_tdata[c*DW +: DW]   = '0;
                s_tkeep[c*KW +: KW]   = '0;
                s_tlast[c]            = 1'b0;
            end
        end
    end

    // Monitor: compares every master beat against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            fire      = '0;
            in_pkt    = 1'b0;
            have_prev = 1'b0;
            lowcnt    = 0;
        end else begin
            fire = s_tvalid & s_tready;
            if (m_tvalid && sb.size() > 0)
                chk("s_tready", DW'(s_tready), m_tready ? DW'(3'b001 << sb[0].ch) : '0);
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got grant %b data %0h, expected no beat", grant, m_tdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("beat_data", m_tdata, e.d);
                    chk("beat_ctl", DW'({grant, m_tkeep, m_tlast}), DW'({3'b001 << e.ch, e.k, e.l}));
                end
                if (!in_pkt) begin
                    if (chk_gap && have_prev) chk("gap_cycles", DW'(lowcnt), DW'(GAP + 1));
                    in_pkt = 1'b1;
                end
                if (m_tlast) begin
                    in_pkt    = 1'b0;
                    have_prev = 1'b1;
                    lowcnt    = 0;
                end
            end else if (!m_tvalid) begin
                lowcnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [11];
        bit [3:0] pat;
        tv[0]  = '{1'b0, 3'b111, 2'd0};
        tv[1]  = '{1'b0, 3'b111, 2'd1};
        tv[2]  = '{1'b0, 3'b101, 2'd2};
        tv[3]  = '{1'b0, 3'b110, 2'd1};
        tv[4]  = '{1'b1, 3'b111, 2'd0};
        tv[5]  = '{1'b0, 3'b001, 2'd0};
        tv[6]  = '{1'b0, 3'b101, 2'd2};
        tv[7]  = '{1'b1, 3'b011, 2'd0};
        tv[8]  = '{1'b0, 3'b100, 2'd2};
        tv[9]  = '{1'b0, 3'b010, 2'd1};
        tv[10] = '{1'b0, 3'b011, 2'd0};
        for (int c = 0; c < 3; c++) exp_cnt[c] = '0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk_quiet("reset");
        chk_cnt("reset_cnt");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        step();

        // Round-robin with all three sources competing
        chk_gap = 1'b1;
        make_pkt(0, 4, 1'b0);
        make_pkt(1, 4, 1'b0);
        make_pkt(2, 4, 1'b0);
        wait_sb(200, "rr");
        chk_gap = 1'b0;
        repeat (4) step();
        chk("rr_cnt", DW'(pkt_cnt), DW'({32'd1, 32'd1, 32'd1}));

        // Arbitration table: single-beat packets on the masked channels
        for (int i = 0; i < 11; i++) begin
            pri_lock = tv[i].lock;
            for (int c = 0; c < 3; c++)
                if (tv[i].mask[c]) make_pkt(c, 1, c != int'(tv[i].exp_ch));
            wait_sb(20, "vec");
            flush_src();
            repeat (4) step();
        end
        pri_lock = 1'b0;
        chk_cnt("table_cnt");

        // Priority lock raised in the middle of a ch1 packet
        make_pkt(1, 8, 1'b0);
        for (int k = 0; k < 50 && sb.size() > 5; k++) step();
        pri_lock = 1'b1;
        make_pkt(0, 2, 1'b0);
        make_pkt(2, 2, 1'b1);
        wait_sb(100, "lock_seq");
        repeat (6) step();
        chk("lock_hold_ch2", DW'(grant), '0);
        release_held();
        pri_lock = 1'b0;
        wait_sb(50, "lock_release");
        repeat (4) step();

        // Lock with ch0 idle: nothing is granted
        pri_lock = 1'b1;
        make_pkt(1, 2, 1'b1);
        for (int k = 0; k < 20; k++) begin
            step();
            chk_quiet("lock_idle");
        end
        release_held();
        pri_lock = 1'b0;
        step();
        chk("unlock_grant", DW'(grant), DW'(3'b010));
        wait_sb(20, "unlock");
        repeat (4) step();
        chk_cnt("lock_cnt");

        // Backpressure on a ch2 packet
        make_pkt(2, 5, 1'b0);
        pat = 4'b1001;
        for (int k = 0; k < 100 && sb.size() > 0; k++) begin
            m_tready = pat[k % 4];
            step();
        end
        m_tready = 1'b1;
        wait_sb(1, "bp");
        repeat (4) step();
        chk_cnt("bp_cnt");

        // Reset in the middle of a ch1 packet
        make_pkt(1, 6, 1'b0);
        for (int k = 0; k < 50 && sb.size() > 4; k++) step();
        rst = 1'b1;
        #1;
        chk_quiet("midrst");
        chk("midrst_cnt", DW'(pkt_cnt), '0);
        sb.delete();
        flush_src();
        for (int c = 0; c < 3; c++) exp_cnt[c] = '0;
        repeat (2) step();
        rst = 1'b0;
        step();
        make_pkt(0, 2, 1'b0);
        make_pkt(1, 2, 1'b0);
        make_pkt(2, 1, 1'b0);
        wait_sb(100, "post_rst");
        repeat (4) step();
        chk_cnt("post_rst_cnt");

        // Counter wrap on ch1
        force dut.cnt1_q = 32'hFFFF_FFFF;
        step();
        release dut.cnt1_q;
        exp_cnt[1] = 32'hFFFF_FFFF;
        step();
        chk("wrap_preload", DW'(pkt_cnt[63:32]), DW'(32'hFFFF_FFFF));
        make_pkt(1, 1, 1'b0);
        wait_sb(20, "wrap");
        repeat (4) step();
        chk("wrap_ch1", DW'(pkt_cnt[63:32]), '0);
        chk_cnt("wrap_cnt");
        chk("wrap_grant", DW'(grant), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aurora_tx_arb.md
Name: aurora_tx_arb

Overview:
- Packet-granular arbiter that shares the single Aurora TX AXI-stream (128-bit) among three sources:
  - ch0: buffer-clear / end-packet pop generator.
  - ch1: ADC data stream.
  - ch2: config/status response stream.
- Grants are held from first beat to tlast, so packets are never interleaved.
- Fair round-robin between sources, with a priority lock driven by the pop generator's busy flag. This lets clear/end packets preempt new data packets at packet boundaries.
- Sits between the source muxes and the Aurora framing core's TX user interface.

Parameters:
- DATA_WD, 128, stream data width in bits; tkeep width is DATA_WD/8.
- GAP_CYC, 2, idle cycles inserted on the master side after every packet (0..15; 0 means no gap).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pri_lock  in  1  when high, only ch0 may be granted at arbitration (tie to pop_en)
- s_tdata  in  3*DATA_WD  packed slave data, ch0 at LSBs
- s_tkeep  in  3*DATA_WD/8  packed slave keep
- s_tvalid  in  3  per-channel valid
- s_tlast  in  3  per-channel last
- s_tready  out  3  per-channel ready
- m_tdata  out  DATA_WD  master data
- m_tkeep  out  DATA_WD/8  master keep
- m_tvalid  out  1  master valid
- m_tlast  out  1  master last
- m_tready  in  1  master ready
- grant  out  3  one-hot current owner; 0 when no owner
- busy  out  1  high in XFER or GAP
- pkt_cnt  out  96  packed 32-bit per-channel completed-packet counters, ch0 at LSBs

Behaviour:
- Reset (async, rst=1), all outputs and state cleared:
  - state=IDLE, grant=0, busy=0, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, s_tready=0, pkt_cnt=0.
  - last_grant=ch2, so ch0 is first in round-robin order.
  - Reset mid-packet aborts the packet immediately; no tlast is generated.
- States: IDLE, XFER, GAP.
- IDLE, evaluated each cycle on s_tvalid:
  - pri_lock=1 and s_tvalid[0]=1: grant ch0.
  - pri_lock=1 and s_tvalid[0]=0: no grant; stay IDLE, even if ch1/ch2 are valid.
  - pri_lock=0: grant the first valid channel scanning last_grant+1, +2, +3 (mod 3).
  - On grant: register the one-hot grant, update last_grant, go to XFER.
  - Latency: s_tvalid seen in cycle N gives grant in N+1; the first beat can transfer in N+1.
- XFER:
  - m_tdata, m_tkeep, m_tvalid and m_tlast are combinationally routed from the granted channel.
  - s_tready[g]=m_tready; all other s_tready=0.
  - A beat transfers when m_tvalid & m_tready.
  - On a transferring beat with m_tlast=1: pkt_cnt[g]+=1, grant clears next cycle, go to GAP (or IDLE when GAP_CYC=0).
  - pri_lock changes during XFER do not affect the current packet.
  - Granted source dropping tvalid mid-packet: hold grant indefinitely; no timeout.
- GAP:
  - Counts GAP_CYC cycles, then returns to IDLE.
  - m_tvalid=0 and s_tready=0 throughout; busy=1.
- Outside XFER: m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0.
- m_tready low: outputs follow the granted source unchanged (AXI hold rule is the source's duty); no beats are counted.
- pkt_cnt: each counter wraps from 0xFFFFFFFF to 0; it is never cleared except by rst.
- Single-beat packet (tlast on the first beat) is legal: one XFER cycle when m_tready=1.
- busy = (state != IDLE).

Test Plan:
- Round-robin: ch0, ch1, ch2 each hold a valid 4-beat packet, pri_lock=0, m_tready=1, GAP_CYC=2 -> packet order ch0, ch1, ch2; m_tvalid low exactly 2 cycles between packets plus 1 arbitration cycle; pkt_cnt={1,1,1}.
- Priority lock: ch1 mid 8-beat packet, pri_lock rises, ch0 and ch2 become valid -> ch1 packet completes intact, ch0 is granted next, ch2 is not granted until pri_lock=0.
- Lock without ch0: pri_lock=1, only ch1 valid for 20 cycles -> grant=0 and m_tvalid=0 throughout; pri_lock falls -> ch1 granted the next cycle.
- Backpressure: ch2 5-beat packet, m_tready toggling 1,0,0,1 -> exactly 5 beats transferred, tdata sequence preserved, s_tready[2] mirrors m_tready, other s_tready=0.
- Reset mid-packet: rst pulsed during beat 3 of a ch1 packet -> all outputs 0 asynchronously, pkt_cnt=0; after release ch0 is the first channel granted.
- Counter wrap: force pkt_cnt[1]=0xFFFFFFFF, send one ch1 single-beat packet -> pkt_cnt[1]=0, grant returns to 0.
